cache_refill_ctrl: RTL

- Miss-service engine directly downstream of the data cache in the pipelined core's memory stage.
- On a cache miss, it writes back the dirty victim line word-by-word, then fetches the missing line from backing memory over a req/ack word port.
- It returns the full line to the cache with a one-cycle done pulse. The cache holds miss_stall high for the whole transaction.

---
 rtl/cache_refill_ctrl_if.sv | 46 ++++
 rtl/cache_refill_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_ctrl_if
//  Description : Bundle of the cache-side miss handshake and the memory-side
//                word request/ack port of the refill controller.
//                master = cache + backing memory, slave = refill controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface cache_refill_ctrl_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
);
    // cache side
    logic                                 miss_req;
    logic [ADDR_WIDTH-1:0]                miss_addr;
    logic                                 victim_dirty;
    logic [ADDR_WIDTH-1:0]                victim_addr;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] victim_data;
    logic                                 busy;
    logic                                 miss_done;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] fill_data;
    logic                                 crit_valid;
    // memory side
    logic                                 mem_req;
    logic                                 mem_we;
    logic [ADDR_WIDTH-1:0]                mem_addr;
    logic [DATA_WIDTH-1:0]                mem_wdata;
    logic                                 mem_ack;
    logic [DATA_WIDTH-1:0]                mem_rdata;

    modport master (
        output miss_req, miss_addr, victim_dirty, victim_addr, victim_data,
        output mem_ack, mem_rdata,
        input  busy, miss_done, fill_data, crit_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  miss_req, miss_addr, victim_dirty, victim_addr, victim_data,
        input  mem_ack, mem_rdata,
        output busy, miss_done, fill_data, crit_valid,
        output mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_ctrl
//  Description : Data-cache miss service engine. Writes back a dirty victim
//                line word by word, then fetches the missing line over a
//                req/ack word port and returns it with a one-cycle done pulse.
//                Optional macro CRITICAL_WORD_FIRST_EN: fill starts at the
//                missed word and wraps, with a crit_valid pulse after the
//                first fill word lands.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                clk,
    input  logic                rst,
    cache_refill_ctrl_if.slave  bus
);

    localparam int c_OFF_W = $clog2(WORDS_PER_LINE);
    localparam int c_LSB   = c_OFF_W + 2;
    localparam int c_TAG_W = ADDR_WIDTH - c_LSB;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WB   = 2'd1;
    localparam logic [1:0] c_FILL = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]            r_state;
    logic [c_OFF_W-1:0]    r_cnt;
    logic                  r_skip;
    logic [c_TAG_W-1:0]    r_victim_base;
    logic [c_TAG_W-1:0]    r_fill_base;
    logic [DATA_WIDTH-1:0] r_victim_words [WORDS_PER_LINE];
    logic [DATA_WIDTH-1:0] r_fill_words   [WORDS_PER_LINE];
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
`ifdef CRITICAL_WORD_FIRST_EN
    logic [c_OFF_W-1:0]    r_offset;
    logic                  r_crit_valid;
`endif

    logic [c_OFF_W-1:0]    w_cnt_inc;
    logic [c_OFF_W-1:0]    w_idx;
    logic [c_OFF_W-1:0]    w_idx_inc;
    logic [c_OFF_W-1:0]    w_fill_start;
    logic                  w_last;
    logic                  w_unused;

    // Word index arithmetic; all counters wrap naturally at the line size.
    always_comb begin
        w_cnt_inc = r_cnt + c_OFF_W'(1);
        w_last    = &r_cnt;
`ifdef CRITICAL_WORD_FIRST_EN
        w_fill_start = r_offset;
        w_idx        = r_offset + r_cnt;
`else
        w_fill_start = '0;
        w_idx        = r_cnt;
`endif
        w_idx_inc = w_idx + c_OFF_W'(1);
    end

    // Byte-in-line bits of the incoming addresses are not needed beyond the offset.
    assign w_unused = ^{bus.miss_addr[c_LSB-1:0], bus.victim_addr[c_LSB-1:0]};

    // Refill FSM: the first request of a transaction is issued one cycle after
    // acceptance; afterwards mem_req stays up and the next address is loaded
    // on the ack edge, including the WB-to-FILL handover.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_skip      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            for (int i = 0; i < WORDS_PER_LINE; i++) r_fill_words[i] <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            r_offset     <= '0;
            r_crit_valid <= 1'b0;
`endif
        end else begin
`ifdef CRITICAL_WORD_FIRST_EN
            r_crit_valid <= 1'b0;
`endif
            case (r_state)
                c_IDLE: begin
                    r_skip <= 1'b0;
                    // The first IDLE cycle after DONE ignores a lingering miss_req.
                    if (bus.miss_req && !r_skip) begin
                        r_fill_base   <= bus.miss_addr[ADDR_WIDTH-1:c_LSB];
                        r_victim_base <= bus.victim_addr[ADDR_WIDTH-1:c_LSB];
                        for (int i = 0; i < WORDS_PER_LINE; i++)
                            r_victim_words[i] <= bus.victim_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef CRITICAL_WORD_FIRST_EN
                        r_offset <= bus.miss_addr[c_LSB-1:2];
`endif
                        r_cnt   <= '0;
                        r_state <= bus.victim_dirty ? c_WB : c_FILL;
                    end
                end
                c_WB: begin
                    if (!r_mem_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {r_victim_base, r_cnt, 2'b00};
                        r_mem_wdata <= r_victim_words[r_cnt];
                    end else if (bus.mem_ack) begin
                        r_cnt <= w_cnt_inc;
                        if (w_last) begin
                            r_state     <= c_FILL;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= {r_fill_base, w_fill_start, 2'b00};
                            r_mem_wdata <= '0;
                        end else begin
                            r_mem_addr  <= {r_victim_base, w_cnt_inc, 2'b00};
                            r_mem_wdata <= r_victim_words[w_cnt_inc];
                        end
                    end
                end
                c_FILL: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {r_fill_base, w_idx, 2'b00};
                    end else if (bus.mem_ack) begin
                        r_fill_words[w_idx] <= bus.mem_rdata;
                        r_cnt               <= w_cnt_inc;
`ifdef CRITICAL_WORD_FIRST_EN
                        if (r_cnt == '0) r_crit_valid <= 1'b1;
`endif
                        if (w_last) begin
                            r_state    <= c_DONE;
                            r_mem_req  <= 1'b0;
                            r_mem_addr <= '0;
                        end else begin
                            r_mem_addr <= {r_fill_base, w_idx_inc, 2'b00};
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_skip  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != c_IDLE);
    assign bus.miss_done = (r_state == c_DONE);
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
`ifdef CRITICAL_WORD_FIRST_EN
    assign bus.crit_valid = r_crit_valid;
`else
    assign bus.crit_valid = 1'b0;
`endif

    // Repack the fill words into the flat line bus.
    for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_pack
        assign bus.fill_data[g*DATA_WIDTH +: DATA_WIDTH] = r_fill_words[g];
    end

endmodule
`default_nettype wire
